// File: rtl/seq_controle_iterativo.sv
// Purpose: sequences the X/H/S register datapath through LOAD, a 4-step loop body
//   repeated n_iter times, FINAL and DONE. It adds run-time iteration count, abort,
//   busy, a sticky result_valid and a selectable done handshake.
// Latency: start accepted at edge 0 -> done high in cycle 4*n+3.
// Backpressure: none. start is sampled only in IDLE. With HOLD_DONE=1, DONE is held while start=1.
//
// Ports:
//   clk, rst          clock (rising edge), synchronous active-high reset
//   start             run request, sampled only in IDLE
//   abort             return to IDLE from any non-IDLE state (no done)
//   n_iter            loop count, latched on start acceptance
//   m0, m1, m2        datapath mux selects
//   ld_x, ld_h, ld_s  register load enables
//   h_sel             H-path enable
//   busy, done        status: busy outside IDLE, done in DONE
//   result_valid      set on DONE entry; cleared on start accept, abort or reset
//   iter_idx          0-based index of the current loop iteration
module seq_controle_iterativo #(
  parameter int ITER_W    = 4,
  parameter bit HOLD_DONE = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              start,
  input  logic              abort,
  input  logic [ITER_W-1:0] n_iter,
  output logic [1:0]        m0,
  output logic [1:0]        m1,
  output logic [1:0]        m2,
  output logic              ld_x,
  output logic              ld_h,
  output logic              ld_s,
  output logic              h_sel,
  output logic              busy,
  output logic              done,
  output logic              result_valid,
  output logic [ITER_W-1:0] iter_idx
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_LOAD  = 3'd1,
    S_B0    = 3'd2,
    S_B1    = 3'd3,
    S_B2    = 3'd4,
    S_B3    = 3'd5,
    S_FINAL = 3'd6,
    S_DONE  = 3'd7
  } state_t;

  localparam logic [ITER_W-1:0] ITER_ONE  = ITER_W'(1);
  localparam logic [ITER_W-1:0] ITER_ZERO = '0;

  state_t            state_q, state_d;
  logic [ITER_W-1:0] iter_q, iter_d;
  logic [ITER_W-1:0] n_q, n_d;
  logic              rv_q, rv_d;

  // Exit compare uses n-1 so that n at the top of the range never needs
  // iter_idx to count up to n. The counter stops at n-1 and cannot wrap.
  // n_q is never 0 in B3 because LOAD skips the loop body when n=0.
  logic [ITER_W-1:0] last_idx;
  assign last_idx = n_q - ITER_ONE;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      iter_q  <= ITER_ZERO;
      n_q     <= ITER_ZERO;
      rv_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      iter_q  <= iter_d;
      n_q     <= n_d;
      rv_q    <= rv_d;
    end
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    iter_d  = iter_q;
    n_d     = n_q;
    rv_d    = rv_q;

    if (state_q != S_IDLE && abort) begin
      // abort outranks every other transition, including the DONE exit.
      state_d = S_IDLE;
      rv_d    = 1'b0;
    end else begin
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            state_d = S_LOAD;
            n_d     = n_iter;
            iter_d  = ITER_ZERO;
            rv_d    = 1'b0;
          end
        end
        S_LOAD:  state_d = (n_q != ITER_ZERO) ? S_B0 : S_FINAL;
        S_B0:    state_d = S_B1;
        S_B1:    state_d = S_B2;
        S_B2:    state_d = S_B3;
        S_B3: begin
          if (iter_q == last_idx) begin
            state_d = S_FINAL;
          end else begin
            state_d = S_B0;
            iter_d  = iter_q + ITER_ONE;
          end
        end
        S_FINAL: begin
          state_d = S_DONE;
          rv_d    = 1'b1;
        end
        S_DONE: begin
          if (HOLD_DONE && start) begin
            state_d = S_DONE;
          end else begin
            state_d = S_IDLE;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  // Moore output decode
  always_comb begin
    m0    = 2'd0;
    m1    = 2'd0;
    m2    = 2'd0;
    ld_x  = 1'b0;
    ld_h  = 1'b0;
    ld_s  = 1'b0;
    h_sel = 1'b0;
    busy  = (state_q != S_IDLE);
    done  = (state_q == S_DONE);

    unique case (state_q)
      S_LOAD: begin
        ld_x = 1'b1;
        m1   = 2'd1;
      end
      S_B0: begin
        ld_s  = 1'b1;
        h_sel = 1'b1;
        m1    = 2'd1;
      end
      S_B1: begin
        ld_h  = 1'b1;
        h_sel = 1'b1;
        m0    = 2'd1;
        m2    = 2'd2;
      end
      S_B2: begin
        ld_s  = 1'b1;
        h_sel = 1'b1;
        m0    = 2'd2;
      end
      S_B3: begin
        ld_h = 1'b1;
        m1   = 2'd2;
        m2   = 2'd3;
      end
      S_FINAL: begin
        ld_s = 1'b1;
        m0   = 2'd3;
        m2   = 2'd3;
      end
      default: begin
        // IDLE and DONE drive no selects or enables.
      end
    endcase
  end

  assign result_valid = rv_q;
  assign iter_idx     = iter_q;

endmodule

// File: tb/tb_seq_controle_iterativo.sv
module tb_seq_controle_iterativo;

  localparam int ITER_W = 4;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  // Instance 0: pulse done. Instance 1: hold-done handshake.
  logic              start0, abort0, start1, abort1;
  logic [ITER_W-1:0] n_iter0, n_iter1;
  logic [1:0]        m0_0, m1_0, m2_0, m0_1, m1_1, m2_1;
  logic              ldx0, ldh0, lds0, hs0, busy0, done0, rv0;
  logic              ldx1, ldh1, lds1, hs1, busy1, done1, rv1;
  logic [ITER_W-1:0] iter0, iter1;

  seq_controle_iterativo #(.ITER_W(ITER_W), .HOLD_DONE(1'b0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .n_iter(n_iter0),
    .m0(m0_0), .m1(m1_0), .m2(m2_0), .ld_x(ldx0), .ld_h(ldh0), .ld_s(lds0),
    .h_sel(hs0), .busy(busy0), .done(done0), .result_valid(rv0), .iter_idx(iter0)
  );

  seq_controle_iterativo #(.ITER_W(ITER_W), .HOLD_DONE(1'b1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .abort(abort1), .n_iter(n_iter1),
    .m0(m0_1), .m1(m1_1), .m2(m2_1), .ld_x(ldx1), .ld_h(ldh1), .ld_s(lds1),
    .h_sel(hs1), .busy(busy1), .done(done1), .result_valid(rv1), .iter_idx(iter1)
  );

  // Observed output bundle: {m0,m1,m2,ld_x,ld_h,ld_s,h_sel,busy,done}
  logic [11:0] obs0, obs1;
  assign obs0 = {m0_0, m1_0, m2_0, ldx0, ldh0, lds0, hs0, busy0, done0};
  assign obs1 = {m0_1, m1_1, m2_1, ldx1, ldh1, lds1, hs1, busy1, done1};

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
  endtask

  // Reference model. Steps: 0 IDLE, 1 LOAD, 2..5 B0..B3, 6 FINAL, 7 DONE.
  function automatic logic [11:0] mk(int a, int b, int c, int x, int h, int s, int hs, int bz, int d);
    logic [1:0] a2, b2, c2;
    a2 = a[1:0]; b2 = b[1:0]; c2 = c[1:0];
    return {a2, b2, c2, x[0], h[0], s[0], hs[0], bz[0], d[0]};
  endfunction

  function automatic logic [11:0] exp_out(int step);
    case (step)
      1:       return mk(0, 1, 0, 1, 0, 0, 0, 1, 0);
      2:       return mk(0, 1, 0, 0, 0, 1, 1, 1, 0);
      3:       return mk(1, 0, 2, 0, 1, 0, 1, 1, 0);
      4:       return mk(2, 0, 0, 0, 0, 1, 1, 1, 0);
      5:       return mk(0, 2, 3, 0, 1, 0, 0, 1, 0);
      6:       return mk(3, 0, 3, 0, 0, 1, 0, 1, 0);
      7:       return mk(0, 0, 0, 0, 0, 0, 0, 1, 1);
      default: return 12'd0;
    endcase
  endfunction

  // Step occupied in cycle c (1-based, cycle 1 follows the accepting edge) for count n.
  function automatic int step_of(int n, int c);
    if (c == 1) return 1;
    if (c <= 4 * n + 1) return 2 + ((c - 2) % 4);
    if (c == 4 * n + 2) return 6;
    return 7;
  endfunction

  function automatic int iter_of(int n, int c);
    if (c == 1) return 0;
    if (c <= 4 * n + 1) return (c - 2) / 4;
    return (n == 0) ? 0 : n - 1;
  endfunction

  // One run on instance 0. The sequence starts at the current negedge.
  // abort_at = cycle in which abort is driven (-1 = none).
  // With noise set, start and n_iter are randomised while busy.
  task automatic run_seq(input int n, input int abort_at, input bit noise,
                         output int done_cyc, output int cx, output int ch,
                         output int cs, output int last_iter);
    int  len;
    bit  aborted;
    int  held_iter;
    len = 4 * n + 3;
    aborted = 0; held_iter = 0;
    done_cyc = 0; cx = 0; ch = 0; cs = 0;
    n_iter0 = n[ITER_W-1:0]; start0 = 1'b1; abort0 = 1'b0;
    for (int c = 1; c <= len; c++) begin
      @(negedge clk);
      chk($sformatf("out_n%0d_c%0d", n, c), 32'(obs0), 32'(exp_out(step_of(n, c))));
      chk($sformatf("iter_n%0d_c%0d", n, c), 32'(iter0), 32'(iter_of(n, c)));
      chk($sformatf("rv_n%0d_c%0d", n, c), 32'(rv0), (c == len) ? 32'd1 : 32'd0);
      if (done0 && done_cyc == 0) done_cyc = c;
      cx += int'(ldx0); ch += int'(ldh0); cs += int'(lds0);
      abort0 = (c == abort_at);
      start0 = (noise && c < len && c != abort_at) ? 1'($urandom_range(0, 1)) : 1'b0;
      if (noise) n_iter0 = ITER_W'($urandom);
      if (c == abort_at) begin
        aborted   = 1;
        held_iter = iter_of(n, c);
        break;
      end
    end
    @(negedge clk);
    abort0 = 1'b0;
    start0 = 1'b0;
    chk($sformatf("idle_out_n%0d", n), 32'(obs0), 32'd0);
    chk($sformatf("idle_rv_n%0d", n), 32'(rv0), aborted ? 32'd0 : 32'd1);
    chk($sformatf("idle_iter_n%0d", n), 32'(iter0),
        aborted ? 32'(held_iter) : 32'((n == 0) ? 0 : n - 1));
    last_iter = int'(iter0);
  endtask

  typedef struct {
    int n;
    int done_cyc;
    int cx;
    int ch;
    int cs;
    int last_iter;
  } vec_t;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t vecs[5];
    int dc, cx, ch, cs, li;

    vecs[0] = '{n: 3,  done_cyc: 15, cx: 1, ch: 6,  cs: 7,  last_iter: 2};
    vecs[1] = '{n: 0,  done_cyc: 3,  cx: 1, ch: 0,  cs: 1,  last_iter: 0};
    vecs[2] = '{n: 15, done_cyc: 63, cx: 1, ch: 30, cs: 31, last_iter: 14};
    vecs[3] = '{n: 1,  done_cyc: 7,  cx: 1, ch: 2,  cs: 3,  last_iter: 0};
    vecs[4] = '{n: 7,  done_cyc: 31, cx: 1, ch: 14, cs: 15, last_iter: 6};

    rst = 1'b1;
    start0 = 1'b0; abort0 = 1'b0; n_iter0 = '0;
    start1 = 1'b0; abort1 = 1'b0; n_iter1 = '0;
    repeat (2) @(negedge clk);
    chk("reset_out0", 32'(obs0), 32'd0);
    chk("reset_rv0", 32'(rv0), 32'd0);
    chk("reset_iter0", 32'(iter0), 32'd0);
    chk("reset_out1", 32'(obs1), 32'd0);
    rst = 1'b0;
    @(negedge clk);

    // Abort in IDLE is ignored.
    abort0 = 1'b1;
    @(negedge clk);
    abort0 = 1'b0;
    chk("abort_idle_out", 32'(obs0), 32'd0);

    // Table: latency, strobe counts and final index.
    foreach (vecs[i]) begin
      run_seq(vecs[i].n, -1, 1'b0, dc, cx, ch, cs, li);
      chk($sformatf("tbl%0d_done_cyc", i), 32'(dc), 32'(vecs[i].done_cyc));
      chk($sformatf("tbl%0d_ld_x", i), 32'(cx), 32'(vecs[i].cx));
      chk($sformatf("tbl%0d_ld_h", i), 32'(ch), 32'(vecs[i].ch));
      chk($sformatf("tbl%0d_ld_s", i), 32'(cs), 32'(vecs[i].cs));
      chk($sformatf("tbl%0d_last_iter", i), 32'(li), 32'(vecs[i].last_iter));
    end

    // Abort in B2 of iteration 1 (cycle 8 for n=3). A new start is then accepted in the idle cycle.
    run_seq(3, 8, 1'b0, dc, cx, ch, cs, li);
    chk("abort_no_done", 32'(dc), 32'd0);
    run_seq(2, -1, 1'b0, dc, cx, ch, cs, li);
    chk("after_abort_done_cyc", 32'(dc), 32'd11);

    // Reset in B1 (cycle 3): all outputs cleared next cycle.
    n_iter0 = 4'd3; start0 = 1'b1;
    @(negedge clk); start0 = 1'b0;
    @(negedge clk);
    @(negedge clk);
    chk("pre_rst_in_b1", 32'(obs0), 32'(exp_out(3)));
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    chk("rst_mid_out", 32'(obs0), 32'd0);
    chk("rst_mid_rv", 32'(rv0), 32'd0);
    chk("rst_mid_iter", 32'(iter0), 32'd0);

    // n_iter and start changing while busy do not alter the sequence length.
    run_seq(5, -1, 1'b1, dc, cx, ch, cs, li);
    chk("noise_done_cyc", 32'(dc), 32'd23);

    // Randomised runs against the model, some with a random abort.
    for (int r = 0; r < 12; r++) begin
      int n, ab;
      n  = int'($urandom_range(0, 15));
      ab = ($urandom_range(0, 2) == 0) ? int'($urandom_range(1, 4 * n + 3)) : -1;
      run_seq(n, ab, 1'b1, dc, cx, ch, cs, li);
      chk($sformatf("rnd%0d_done_cyc", r), 32'(dc), (ab < 0) ? 32'(4 * n + 3) : 32'((ab == 4 * n + 3) ? ab : 0));
    end

    // HOLD_DONE=1: n=2, start held high. DONE from cycle 11, held through cycle 14.
    n_iter1 = 4'd2; start1 = 1'b1;
    for (int c = 1; c <= 14; c++) begin
      @(negedge clk);
      chk($sformatf("hold_out_c%0d", c), 32'(obs1), 32'(exp_out(step_of(2, c))));
      chk($sformatf("hold_rv_c%0d", c), 32'(rv1), (c >= 11) ? 32'd1 : 32'd0);
      if (c == 14) start1 = 1'b0;
    end
    @(negedge clk);
    chk("hold_release_out", 32'(obs1), 32'd0);
    chk("hold_release_rv", 32'(rv1), 32'd1);
    chk("hold_release_iter", 32'(iter1), 32'd1);
    @(negedge clk);
    chk("hold_stays_idle", 32'(obs1), 32'd0);

    // HOLD_DONE=1: abort outranks staying in DONE.
    n_iter1 = 4'd0; start1 = 1'b1;
    repeat (3) @(negedge clk);
    chk("hold_abort_in_done", 32'(obs1), 32'(exp_out(7)));
    abort1 = 1'b1;
    @(negedge clk);
    abort1 = 1'b0; start1 = 1'b0;
    chk("hold_abort_out", 32'(obs1), 32'd0);
    chk("hold_abort_rv", 32'(rv1), 32'd0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
